ptmch_spi_rx: RTL

SPI slave receive front-end for the pattern-match trigger path. It samples the asynchronous SPI pins (SPI_CS, SPI_CLK, SPI_MOSI) in the CLK200M domain and deserializes MOSI into bytes, MSB first. Each completed byte is delivered as a one-cycle strobe to the downstream pattern-match core, together with frame and error flags. The block sits directly between the board SPI pins and the pattern-match core inside ptmch_top.

---
 rtl/ptmch_pkg.sv | 16 +
 rtl/ptmch_spi_rx_if.sv | 31 +++
 rtl/sync_bit.sv | 27 ++
 rtl/ptmch_spi_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ptmch_pkg.sv
// Shared types and defaults for the pattern-match trigger path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ptmch_pkg;

    // Receive front-end states; ARMING is the reset state.
    typedef enum logic [1:0] {
        ARMING = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } spi_rx_state_t;

    localparam int PTMCH_DATA_W      = 8;
    localparam int PTMCH_SYNC_STAGES = 2;

endpackage

// File: rtl/ptmch_spi_rx_if.sv
// SPI pin inputs and received-word outputs of the SPI receive front-end.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must take every RX_VALID/RX_ERR strobe.
interface ptmch_spi_rx_if
    import ptmch_pkg::*;
#(
    parameter int DATA_W = PTMCH_DATA_W
) ();

    logic              SPI_CS;
    logic              SPI_CLK;
    logic              SPI_MOSI;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_VALID;
    logic              RX_FIRST;
    logic              RX_ERR;
    logic              RX_BUSY;

    // Receiver side: takes the pins, drives the word strobes.
    modport slave (
        input  SPI_CS, SPI_CLK, SPI_MOSI,
        output RX_DATA, RX_VALID, RX_FIRST, RX_ERR, RX_BUSY
    );

    // Pin driver / word consumer side.
    modport master (
        output SPI_CS, SPI_CLK, SPI_MOSI,
        input  RX_DATA, RX_VALID, RX_FIRST, RX_ERR, RX_BUSY
    );

endinterface

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with a configurable reset value.
// Latency: STAGES clock cycles from input change to output change.
// Backpressure: none.
module sync_bit #(
    parameter int   STAGES  = 2,    // must be at least 2
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ptmch_spi_rx.sv
// SPI mode-0 slave receiver: synchronizes pins, deserializes MOSI MSB-first into words.
// Latency: SYNC_STAGES+2 cycles from last SPI_CLK pin rise to RX_VALID (same for CS rise to RX_ERR).
// Backpressure: none; one-cycle strobes, words are far enough apart that no buffering is needed.
module ptmch_spi_rx
    import ptmch_pkg::*;
#(
    parameter int DATA_W      = PTMCH_DATA_W,
    parameter int SYNC_STAGES = PTMCH_SYNC_STAGES
) (
    input  logic            CLK200M,
    input  logic            RESET,
    ptmch_spi_rx_if.slave   bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FL_W  = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // Synchronized pins
    logic cs_s;
    logic sclk_s;
    logic mosi_s;

    // Edge-detect history
    logic cs_d_q;
    logic sclk_d_q;
    logic cs_on;
    logic cs_off;
    logic sclk_rise;

    // Control
    spi_rx_state_t state_q, state_d;
    logic [FL_W-1:0] flush_q;
    logic            flush_done;

    // FSM decode outputs
    logic start_frame;
    logic abort_frame;
    logic part_err;
    logic do_shift;
    logic word_done;

    // Datapath
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              first_pend_q;
    logic              done_q;
    logic              done_first_q;
    logic              err_pend_q;

    // Output registers
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              rx_first_q;
    logic              rx_err_q;
    logic              rx_busy_q;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (CLK200M), .rst (RESET), .d_i (bus.SPI_CS),   .q_o (cs_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (CLK200M), .rst (RESET), .d_i (bus.SPI_CLK),  .q_o (sclk_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (CLK200M), .rst (RESET), .d_i (bus.SPI_MOSI), .q_o (mosi_s)
    );

    // Delayed copies of synchronized CS and SCLK for edge detection.
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            cs_d_q   <= 1'b1;
            sclk_d_q <= 1'b0;
        end else begin
            cs_d_q   <= cs_s;
            sclk_d_q <= sclk_s;
        end
    end

    assign cs_on     = ~cs_s &  cs_d_q;
    assign cs_off    =  cs_s & ~cs_d_q;
    assign sclk_rise =  sclk_s & ~sclk_d_q;

    // The synchronizers hold their reset value for SYNC_STAGES cycles after
    // reset, so a CS already low at the pin would read as high until then.
    // ARMING only trusts cs_s once the chain has been refilled from the pin.
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            flush_q <= '0;
        end else if (!flush_done) begin
            flush_q <= flush_q + FL_W'(1);
        end
    end

    assign flush_done = (flush_q == FL_W'(SYNC_STAGES));

    // FSM state register.
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            state_q <= ARMING;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARMING:  if (flush_done && cs_s) state_d = IDLE;
            IDLE:    if (cs_on)              state_d = ACTIVE;
            ACTIVE:  if (cs_off)             state_d = IDLE;
            default:                         state_d = ARMING;
        endcase
    end

    // FSM output decode; cs_off takes priority over a coincident SCLK edge.
    always_comb begin
        start_frame = 1'b0;
        abort_frame = 1'b0;
        part_err    = 1'b0;
        do_shift    = 1'b0;
        word_done   = 1'b0;
        case (state_q)
            IDLE: begin
                start_frame = cs_on;
            end
            ACTIVE: begin
                if (cs_off) begin
                    abort_frame = 1'b1;
                    part_err    = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    do_shift  = 1'b1;
                    word_done = (bit_cnt_q == CNT_LAST);
                end
            end
            default: ;
        endcase
    end

    // Shifter, bit counter and the one-cycle completion/error markers.
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            first_pend_q <= 1'b0;
            done_q       <= 1'b0;
            done_first_q <= 1'b0;
            err_pend_q   <= 1'b0;
        end else begin
            if (start_frame) begin
                bit_cnt_q    <= '0;
                first_pend_q <= 1'b1;
            end else if (abort_frame) begin
                bit_cnt_q <= '0;
            end else if (do_shift) begin
                shift_q   <= {shift_q[DATA_W-2:0], mosi_s};
                bit_cnt_q <= word_done ? '0 : bit_cnt_q + CNT_W'(1);
                if (word_done) begin
                    first_pend_q <= 1'b0;
                end
            end
            done_q       <= word_done;
            done_first_q <= word_done & first_pend_q;
            err_pend_q   <= part_err;
        end
    end

    // Registered outputs; RX_DATA is held until the next completed word.
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            if (done_q) begin
                rx_data_q <= shift_q;
            end
            rx_valid_q <= done_q;
            rx_first_q <= done_q & done_first_q;
            rx_err_q   <= err_pend_q;
            rx_busy_q  <= (state_q == ACTIVE);
        end
    end

    assign bus.RX_DATA  = rx_data_q;
    assign bus.RX_VALID = rx_valid_q;
    assign bus.RX_FIRST = rx_first_q;
    assign bus.RX_ERR   = rx_err_q;
    assign bus.RX_BUSY  = rx_busy_q;

endmodule
